// File: rtl/display_output.sv
// -----------------------------------------------------------------------------
// display_output
//    Board-side output driver for the game. It scans a 4-digit common-anode
//    seven-segment display showing a BCD score, blinks it while the game is
//    paused, and stretches one-cycle hit pulses into visible LED flashes.
//    Every output is a flop, so the pins never glitch.
//
// Ports
//    clk      in   system clock
//    rst_n    in   asynchronous active-low reset
//    digits   in   [15:0] four BCD nibbles, [3:0] = rightmost digit (digit 0)
//    blank_lz in   1 = blank leading zeros
//    paused   in   1 = game stopped, display blinks
//    hit      in   [2:0] one-cycle per-lane hit pulses
//    seg_n    out  [6:0] active-low segments {g,f,e,d,c,b,a}
//    dig_n    out  [3:0] active-low digit enables, bit i = digit i
//    led_n    out  [2:0] active-low lane LEDs
// -----------------------------------------------------------------------------
module display_output #(
   parameter int SCAN_DIV  = 50000,
   parameter int STRETCH   = 5000000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] digits,
   input  logic        blank_lz,
   input  logic        paused,
   input  logic [2:0]  hit,
   output logic [6:0]  seg_n,
   output logic [3:0]  dig_n,
   output logic [2:0]  led_n
);

   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int STR_W   = $clog2(STRETCH + 1);

   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [STR_W-1:0]   STR_LOAD   = STR_W'(STRETCH);

   logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
   logic [1:0]         idx_q,       idx_d;
   logic [15:0]        shadow_q,    shadow_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blink_ph_q,  blink_ph_d;
   logic [6:0]         seg_n_q,     seg_n_d;
   logic [3:0]         dig_n_q,     dig_n_d;
   logic [2:0]         led_n_q,     led_n_d;

   logic [3:0]         blank;
   logic [3:0]         cur_nib;
   logic               scan_wrap;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;   // non-BCD nibble shows a dash
      endcase
      return s;
   endfunction

   // A digit is a leading zero only if it and every digit to its left are 0;
   // the rightmost digit always shows so a zero score reads "0".
   always_comb begin
      blank    = 4'b0000;
      blank[3] = blank_lz && (shadow_q[15:12] == 4'd0);
      blank[2] = blank[3] && (shadow_q[11:8]  == 4'd0);
      blank[1] = blank[2] && (shadow_q[7:4]   == 4'd0);
   end

   assign cur_nib   = shadow_q[{idx_q, 2'b00} +: 4];
   assign scan_wrap = (scan_cnt_q == SCAN_LAST);

   always_comb begin
      scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
      idx_d       = scan_wrap ? idx_q + 2'd1 : idx_q;
      // Shadow only changes at the frame boundary so a frame is never torn.
      shadow_d    = (scan_wrap && (idx_q == 2'd3)) ? digits : shadow_q;
      blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BLINK_W'(1);
      blink_ph_d  = (blink_cnt_q == BLINK_LAST) ? ~blink_ph_q : blink_ph_q;

      // First cycle of each slot is dark so the previous digit cannot ghost.
      if ((scan_cnt_q == '0) || (paused && blink_ph_q)) begin
         dig_n_d = 4'hF;
      end else begin
         dig_n_d = ~(4'b0001 << idx_q);
      end
      seg_n_d = blank[idx_q] ? 7'h7F : seg_decode(cur_nib);
   end

   // One independent retriggerable stretcher per lane.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_lane
         logic [STR_W-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (hit[gi]) begin
               cnt_d = STR_LOAD;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - STR_W'(1);
            end
         end

         // LED is registered from the next count so it tracks the counter exactly.
         assign led_n_d[gi] = (cnt_d == '0);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt_q  <= '0;
         idx_q       <= 2'd0;
         shadow_q    <= 16'h0000;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
         seg_n_q     <= 7'h7F;
         dig_n_q     <= 4'hF;
         led_n_q     <= 3'h7;
      end else begin
         scan_cnt_q  <= scan_cnt_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
         seg_n_q     <= seg_n_d;
         dig_n_q     <= dig_n_d;
         led_n_q     <= led_n_d;
      end
   end

   assign seg_n = seg_n_q;
   assign dig_n = dig_n_q;
   assign led_n = led_n_q;

endmodule

// File: doc/display_output.md
# display_output

Output-side counterpart of the game's input conditioning: it drives the board's user-facing outputs. It time-multiplexes a 4-digit common-anode seven-segment display showing a BCD score and stretches one-cycle per-lane hit pulses into visible LED flashes. The display blinks while the game is stopped. It sits between the game core and the board pins; all outputs are active-low, registered and glitch-free.

## Interface
Parameters:
- SCAN_DIV, default 50000: clk cycles per digit slot (≥2).
- STRETCH, default 5000000: clk cycles an LED stays lit after a hit (≥1).
- BLINK_DIV, default 25000000: clk cycles per blink half-period (≥1).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- digits  in  16  four BCD nibbles; [3:0] is the rightmost digit (digit 0), [15:12] is digit 3.
- blank_lz  in  1  1 = blank leading zeros.
- paused  in  1  1 = game stopped; the display blinks.
- hit  in  3  per-lane pulses, one cycle wide, from the game core.
- seg_n  out  7  active-low segments {g,f,e,d,c,b,a}.
- dig_n  out  4  active-low digit enables; bit i selects digit i.
- led_n  out  3  active-low lane LEDs.

## Operation
- Reset (async, rst_n=0): seg_n=7'h7F, dig_n=4'hF, led_n=3'h7. All counters, idx, blink_ph and the digit shadow register are 0.
- scan_cnt counts 0..SCAN_DIV-1 and wraps. On wrap, idx (2 bits) advances 0→1→2→3→0.
- shadow (16 bits) loads `digits` on the edge where scan_cnt=SCAN_DIV-1 and idx=3, that is, at the frame boundary. The display never shows a mix of old and new values within one frame. After reset, the first frame displays shadow=0.
- The digit decoder uses standard patterns for 0–9, for example 0→7'b1000000 and 8→7'b0000000. Nibbles A–F display "-", which is 7'b0111111.
- Leading-zero blanking applies when blank_lz=1. Digit i (i=3,2,1) is blank when its nibble and all higher nibbles are 0. Digit 0 is never blanked. A blank digit has seg_n=7'h7F while dig_n still scans normally.
- blink_cnt counts 0..BLINK_DIV-1 free-running and toggles blink_ph on each wrap. blink_cnt runs regardless of paused.
- LED stretcher, one counter per lane i:
  - hit[i]=1 loads STRETCH.
  - Otherwise the counter decrements when nonzero.
  - led_n[i] = (counter == 0).
  - A hit while the lane is active reloads the counter (retrigger). Lanes are independent, and hits on several lanes in the same cycle are all honored.
  - blink and paused do not affect the LEDs.

## Timing
- All outputs are registered and computed from pre-edge state on each rising clk edge.
- dig_n <= 4'hF if scan_cnt=0 (one-cycle anti-ghost gap at the start of every slot) or (paused=1 and blink_ph=1). Otherwise dig_n <= ~(4'b0001 << idx).
- seg_n <= decode(shadow nibble idx) with blanking applied. It updates in the same edge as dig_n, so segments and enable never disagree on an active cycle.
- In each slot, a digit is lit for SCAN_DIV-1 cycles, and a full frame lasts 4·SCAN_DIV cycles.
- Change of `digits` to display: the new value reaches the outputs at the next frame boundary. Worst case latency is 4·SCAN_DIV+1 cycles.
- hit[i] sampled high at edge t: led_n[i] goes low after edge t and stays low for exactly STRETCH cycles. It returns high after edge t+STRETCH if there is no retrigger.
- paused is sampled every cycle with no latching. Deasserting paused restores scanning on the next edge, except during an anti-ghost gap cycle.
- Reset mid-operation forces the reset values immediately (asynchronously). Operation resumes with idx=0 on the first edge after rst_n rises.

## Test plan
Use SCAN_DIV=4, STRETCH=3 and BLINK_DIV=8 unless noted.
- Reset check: assert rst_n=0 mid-frame with an LED lit → seg_n=7F, dig_n=F and led_n=7 immediately. After release the first frame shows 0 on digit 0, with digits 3–1 blank when blank_lz=1.
- Scan and decode: digits=16'h1234, blank_lz=0, held over 2 frames → the second frame shows dig_n=E/D/B/7 with seg_n 0011001 ("4"), 0110000 ("3"), 0100100 ("2"), 1111001 ("1"). Each slot is 1 cycle at dig_n=F followed by 3 cycles active.
- Frame atomicity and invalid BCD: change digits from 16'h0000 to 16'h00A7 mid-frame → the current frame stays all-zero. The next frame shows "7" on digit 0 and "-" (0111111) on digit 1.
- Leading zeros: digits=16'h0305, blank_lz=1 → digit 3 blank (seg_n=7F). Digit 2 shows "3", digit 1 shows "0" because it is not leading, and digit 0 shows "5".
- Blink: paused=1 → dig_n is F for all of each 8-cycle interval where blink_ph=1 and scans normally while blink_ph=0. After paused=0, normal scanning resumes within 1 cycle.
- LED stretch and retrigger: hit=3'b001 at t → led_n[0]=0 for cycles t+1..t+3. hit[0] again at t+2 extends it through t+5. hit=3'b110 in one cycle lights both lanes for 3 cycles, and lane 0 is unaffected.
